// File: rtl/lsu_pkg.sv
// Shared types, byte-enable codes and small data helpers for the LSU data-memory master.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [3:0] BE_WORD  = 4'b0000;
  localparam logic [3:0] BE_BYTE  = 4'b1000;
  localparam logic [3:0] BE_HALF  = 4'b0011;
  localparam logic [3:0] BE_SBYTE = 4'b1100;
  localparam logic [3:0] BE_SHALF = 4'b0100;

  // Size code 11 behaves exactly like a word access.
  function automatic size_e norm_size(input logic [1:0] sz);
    if (sz == 2'd3) begin
      norm_size = SZ_WORD;
    end else begin
      norm_size = size_e'(sz);
    end
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] d, input size_e sz);
    case (sz)
      SZ_BYTE: store_data = {24'd0, d[7:0]};
      SZ_HALF: store_data = {16'd0, d[15:0]};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] k);
    case (k)
      2'd0:    byte_sel = d[7:0];
      2'd1:    byte_sel = d[15:8];
      2'd2:    byte_sel = d[23:16];
      default: byte_sel = d[31:24];
    endcase
  endfunction

  function automatic logic [1:0] last_byte(input size_e sz);
    if (sz == SZ_HALF) begin
      last_byte = 2'd1;
    end else begin
      last_byte = 2'd3;
    end
  endfunction

endpackage

// File: rtl/lsu_be_encode.sv
// Maps access size, signedness and address offset to the memory byte-enable code
// and flags accesses the memory cannot perform in a single cycle.
module lsu_be_encode
  import lsu_pkg::*;
(
  input  size_e      size,
  input  logic       sgn,
  input  logic [1:0] off,
  output logic [3:0] be,
  output logic       misaligned
);

  // Only the low half-lane exists for halfwords, so any non-zero offset must be split.
  always_comb begin
    be         = BE_WORD;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be         = (sgn ? BE_SBYTE : BE_BYTE) | {2'b00, off};
        misaligned = 1'b0;
      end
      SZ_HALF: begin
        be         = sgn ? BE_SHALF : BE_HALF;
        misaligned = (off != 2'b00);
      end
      default: begin
        be         = BE_WORD;
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit driving the byte-enabled data memory; misaligned accesses are split into
// byte cycles, or trapped with rsp_err when LSU_MISALIGN_TRAP_EN is defined.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  state_e        state_r, state_nxt;
  logic          we_r, sgn_r;
  size_e         size_r, req_sz_s;
  logic [AW-1:0] addr_r, mem_a_nxt;
  logic [DW-1:0] wdata_r, mem_wd_nxt, rdata_nxt;
  logic [1:0]    k_r, k_nxt;
  logic [3:0]    be_s, mem_be_nxt;
  logic          mis_s, accept_s, last_s, sext_s;
  logic          mem_we_nxt, valid_nxt, err_nxt;

  assign req_sz_s = norm_size(req_size);
  assign accept_s = req_valid && req_ready;
  assign last_s   = (k_r == last_byte(size_r));
  assign sext_s   = last_s && (size_r == SZ_HALF) && sgn_r;

  lsu_be_encode u_be_encode (
    .size       (req_sz_s),
    .sgn        (req_signed & ~req_we),
    .off        (req_addr[1:0]),
    .be         (be_s),
    .misaligned (mis_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && mis_s) begin
`ifdef LSU_MISALIGN_TRAP_EN
          state_nxt = RESP;
`else
          state_nxt = SPLIT;
`endif
        end else if (accept_s) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: state_nxt = RESP;
`ifndef LSU_MISALIGN_TRAP_EN
      SPLIT: begin
        if (last_s) begin
          state_nxt = RESP;
        end else begin
          state_nxt = SPLIT;
        end
      end
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from the state being entered.
  always_comb begin
    mem_we_nxt = 1'b0;
    mem_be_nxt = BE_WORD;
    mem_a_nxt  = '0;
    mem_wd_nxt = '0;
    k_nxt      = k_r;
    valid_nxt  = (state_nxt == RESP);
    err_nxt    = 1'b0;
    rdata_nxt  = rsp_rdata;
    case (state_nxt)
      ACCESS: begin
        mem_we_nxt = req_we;
        mem_be_nxt = be_s;
        mem_a_nxt  = req_addr;
        mem_wd_nxt = store_data(req_wdata, req_sz_s);
      end
      SPLIT: begin
        if (state_r == IDLE) begin
          k_nxt      = 2'd0;
          mem_a_nxt  = req_addr;
          mem_wd_nxt = {24'd0, req_wdata[7:0]};
          mem_we_nxt = req_we;
        end else begin
          k_nxt      = k_r + 2'd1;
          mem_a_nxt  = addr_r + AW'(k_nxt);
          mem_wd_nxt = {24'd0, byte_sel(wdata_r, k_nxt)};
          mem_we_nxt = we_r;
        end
        mem_be_nxt = {2'b10, mem_a_nxt[1:0]};
      end
      default: mem_we_nxt = 1'b0;
    endcase
    if (accept_s) begin
      rdata_nxt = '0;
    end else if (state_r == ACCESS && !we_r) begin
      rdata_nxt = mem_rd;
    end else if (state_r == SPLIT && !we_r && sext_s) begin
      rdata_nxt = {{16{mem_rd[7]}}, mem_rd[7:0], rsp_rdata[7:0]};
    end else if (state_r == SPLIT && !we_r) begin
      rdata_nxt[{k_r, 3'b000} +: 8] = mem_rd[7:0];
    end else begin
      rdata_nxt = rsp_rdata;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    err_nxt = accept_s && mis_s;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= BE_WORD;
      mem_a     <= '0;
      mem_wd    <= '0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= valid_nxt;
      rsp_rdata <= rdata_nxt;
      rsp_err   <= err_nxt;
      mem_we    <= mem_we_nxt;
      mem_be    <= mem_be_nxt;
      mem_a     <= mem_a_nxt;
      mem_wd    <= mem_wd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      sgn_r   <= 1'b0;
      size_r  <= SZ_BYTE;
      addr_r  <= '0;
      wdata_r <= '0;
      k_r     <= 2'd0;
    end else begin
      k_r <= k_nxt;
      if (accept_s) begin
        we_r    <= req_we;
        sgn_r   <= req_signed;
        size_r  <= req_sz_s;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Randomized self-checking bench: byte-array reference model plus a behavioural memory
// that honours the byte-enable code.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:511];
  logic        mem_ready = 1'b0;
  logic [7:0]  ref_mem [0:2047];
  logic [31:0] tr_a [0:7];
  logic [3:0]  tr_be [0:7];
  logic        tr_we [0:7];
  int          tr_n;

  always #5 clk = ~clk;

  lsu_dmem_master #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [3:0] be);
    logic [7:0] b;
    b = 8'(w >> {be[1:0], 3'b000});
    case (be)
      4'b0000: return w;
      4'b0011: return {16'd0, w[15:0]};
      4'b0100: return {{16{w[15]}}, w[15:0]};
      default: begin
        if (be[3]) return be[2] ? {{24{b[7]}}, b} : {24'd0, b};
        else return 32'd0;
      end
    endcase
  endfunction

  assign mem_rd = mem_read(mem[mem_a[10:2]], mem_be);

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++)
        mem[i] <= {init_byte(4*i+3), init_byte(4*i+2), init_byte(4*i+1), init_byte(4*i)};
    end else if (mem_we) begin
      if (mem_be == 4'b0000) mem[mem_a[10:2]] <= mem_wd;
      else if (mem_be == 4'b0011 || mem_be == 4'b0100) mem[mem_a[10:2]][15:0] <= mem_wd[15:0];
      else mem[mem_a[10:2]][{mem_be[1:0], 3'b000} +: 8] <= mem_wd[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    logic [31:0] v;
    logic [10:0] idx;
    int n;
    n = nbytes(size);
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      idx = 11'(addr + 32'(k));
      v = v | (32'(ref_mem[idx]) << (8 * k));
    end
    if (sgn && n == 1) v = {{24{v[7]}}, v[7:0]};
    else if (sgn && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    logic [10:0] idx;
    for (int k = 0; k < nbytes(size); k++) begin
      idx = 11'(addr + 32'(k));
      ref_mem[idx] = 8'(wdata >> (8 * k));
    end
  endtask

  function automatic logic [3:0] exp_be_aligned(input logic [1:0] size, input logic sgn, input logic [1:0] off);
    if (size == 2'd0) return {1'b1, sgn, off};
    if (size == 2'd1) return sgn ? 4'b0100 : 4'b0011;
    return 4'b0000;
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] got);
    int n, cyc, exp_cyc;
    logic aligned, trap;
    logic [31:0] exp_rd, exp_a;
    n = nbytes(size);
    aligned = (size == 2'd0) || (addr[1:0] == 2'b00);
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = !aligned;
`endif
    exp_rd  = (we || trap) ? 32'd0 : ref_load(size, sgn, addr);
    exp_cyc = trap ? 1 : (aligned ? 2 : n + 1);
    cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    tr_n = 0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid || cyc >= 12) break;
      if (tr_n < 8) begin
        tr_a[tr_n] = mem_a; tr_be[tr_n] = mem_be; tr_we[tr_n] = mem_we;
        tr_n++;
      end
    end
    got = rsp_rdata;
    chk("latency", 32'(cyc), 32'(exp_cyc));
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", rsp_err, trap);
    chk("resp_mem", {mem_we, mem_be}, 32'd0);
    chk("resp_ready", req_ready, 1'b0);
    chk("mem_cycles", 32'(tr_n), 32'(exp_cyc - 1));
    for (int k = 0; k < tr_n && k < exp_cyc - 1; k++) begin
      exp_a = aligned ? addr : addr + 32'(k);
      chk("mem_a", tr_a[k], exp_a);
      chk("mem_we", tr_we[k], we);
      chk("mem_be", tr_be[k], aligned ? exp_be_aligned(size, sgn & ~we, addr[1:0]) : {2'b10, exp_a[1:0]});
    end
    if (we && !trap) ref_store(size, addr, wdata);
  endtask

  initial begin
    logic [31:0] got, a;
    logic [3:0]  be_exp [0:3];
    logic        seen;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp", {rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_ctl", {mem_we, mem_be}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    mem_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", req_ready, 1'b1);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, got);
    chk("st_w_be", tr_be[0], 4'b0000);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, got);
    chk("ld_w", got, 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 32'h23, 32'h80, got);
    chk("st_b_be", tr_be[0], 4'b1011);
    do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'd0, got);
    chk("ld_sb_be", tr_be[0], 4'b1111);
    chk("ld_sb", got, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'd0, got);
    chk("ld_ub", got, 32'h00000080);
    do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h00008001, got);
    do_req(1'b0, 2'd1, 1'b1, 32'h20, 32'd0, got);
    chk("ld_sh_be", tr_be[0], 4'b0100);
    chk("ld_sh", got, 32'hFFFF8001);
    do_req(1'b1, 2'd2, 1'b0, 32'h31, 32'h11223344, got);
`ifndef LSU_MISALIGN_TRAP_EN
    be_exp[0] = 4'b1001; be_exp[1] = 4'b1010; be_exp[2] = 4'b1011; be_exp[3] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      chk("split_a", tr_a[k], 32'h31 + 32'(k));
      chk("split_be", tr_be[k], be_exp[k]);
    end
`endif
    do_req(1'b0, 2'd2, 1'b0, 32'h31, 32'd0, got);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("ld_split_w", got, 32'h11223344);
`endif
    do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'hFE, got);
    do_req(1'b1, 2'd0, 1'b0, 32'h23, 32'hFF, got);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, got);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("ld_split_sh", got, 32'hFFFFFFFE);
`endif
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hA5B6C7D8, got);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("wrap_a", tr_a[2], 32'h00000000);
`endif
    do_req(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'd0, got);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("wrap_ld", got, 32'hA5B6C7D8);

    // Reset during the third byte of a split store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_a", mem_a, 32'h43);
    chk("rst_mid_we_pre", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", mem_we, 1'b0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid) seen = 1'b1;
    chk("rst_mid_no_rsp", seen, 1'b0);
    chk("rst_mid_ready", req_ready, 1'b1);
    ref_mem[11'h41] = 8'h44;
    ref_mem[11'h42] = 8'h33;
    do_req(1'b0, 2'd2, 1'b0, 32'h41, 32'd0, got);
`endif

    for (int i = 0; i < 200; i++) begin
      a = (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 2047));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, got);
    end

    @(negedge clk);
    for (int i = 0; i < 512; i++)
      chk("mem_final", mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
Load/store unit on the CPU side of the byte-enabled data memory port; it is the initiator that drives we/be/a/wd and consumes rd. It accepts one load/store request from the MEM stage via valid/ready and issues one or more memory cycles. Misaligned halfword/word accesses are split into byte accesses. Loaded data is returned zero- or sign-extended.

Parameters:
AW, 32, address width on request and memory side
DW, 32, data width (fixed 32; byte lanes = DW/8 = 4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
req_signed  in  1  sign-extend load result (byte/half only)
req_addr  in  AW  byte address
req_wdata  in  DW  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DW  load result (0 for stores)
rsp_err  out  1  misalignment trap (see Optional Feature)
mem_we  out  1  memory write enable
mem_be  out  4  {byte, signed, lane[1:0]}: 0000 word, 10LL byte, 0011 low half, 11LL signed byte, 0100 signed low half
mem_a  out  AW  memory byte address (memory indexes a[10:2])
mem_wd  out  DW  memory write data
mem_rd  in  DW  combinational memory read data

Behaviour:
- Reset: state IDLE; req_ready=1 after reset release; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_be=0000, mem_a=0, mem_wd=0.
- Handshake: request accepted on posedge where req_valid&&req_ready; all req_* fields registered. No response backpressure.
- States: IDLE -> ACCESS (aligned) or SPLIT (misaligned) -> RESP -> IDLE.
- Aligned = byte any offset; half offset 00; word offset 00. Half at offset 10 is misaligned (memory supports low-half lane only).
- ACCESS (1 cycle): mem_a=addr, mem_we=req_we, mem_be from table: word 0000; byte unsigned 10LL; byte signed 11LL; half unsigned 0011; half signed 0100. Store: mem_wd = wdata (word), {16'b0,wdata[15:0]} (half), {24'b0,wdata[7:0]} (byte). Load: mem_rd captured at end of cycle into rsp_rdata unchanged (memory already extends).
- SPLIT: byte counter k=0..N-1 (N=2 half, 4 word), one byte per cycle: mem_a=addr+k, mem_be={1,0,(addr+k)[1:0]}, mem_wd={24'b0,wdata[8k+7:8k]}, mem_we=req_we. Load: mem_rd[7:0] into result byte k. Address wrap past 2^AW-1 wraps modulo 2^AW. After last byte, signed half load sign-extends bit 15.
- RESP (1 cycle): rsp_valid=1, rsp_rdata valid, mem_we=0, mem_be=0000. Next state IDLE; req_ready rises the following cycle.
- Latency: aligned: rsp_valid 2 cycles after accept; split: N+1 cycles. Max throughput one aligned request / 3 cycles.
- Outside ACCESS/SPLIT mem_we=0 always.
- Reset mid-operation: immediate return to IDLE, mem_we drops asynchronously, no rsp_valid; bytes already written remain in memory.
- req_signed ignored for stores and words.

Optional Feature:
LSU_MISALIGN_TRAP_EN: defined -> misaligned requests do no memory cycle; IDLE -> RESP directly, rsp_valid=1, rsp_err=1, rsp_rdata=0; SPLIT state not built. Undefined -> splitting as above, rsp_err tied 0.

Decomposition:
- lsu_pkg: size enum (SZ_BYTE, SZ_HALF, SZ_WORD), state enum (IDLE, ACCESS, SPLIT, RESP), be constants BE_WORD=4'b0000, BE_BYTE=4'b1000, BE_HALF=4'b0011, BE_SBYTE=4'b1100, BE_SHALF=4'b0100.
- Sub-module lsu_be_encode: combinational (size, signed, addr[1:0]) -> be[3:0], misaligned flag.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 -> mem_be=0000 both, rsp_rdata=0xDEADBEEF 2 cycles after accept.
- Store byte 0x80 @0x23, load signed byte @0x23 -> mem_be=1011 then 1111, rsp_rdata=0xFFFFFF80; unsigned load -> 0x00000080.
- Load signed half @0x20 holding 0x8001 -> mem_be=0100, rsp_rdata=0xFFFF8001.
- Store word 0x11223344 @0x31 (split) -> 4 cycles, mem_a 0x31..0x34, mem_be 1001,1010,1011,1000; load word @0x31 -> 0x11223344, rsp_valid 5 cycles after accept; with LSU_MISALIGN_TRAP_EN -> rsp_err=1 next cycle, mem_we never high.
- Load half @0x22 holding bytes 0xFE,0xFF, signed -> 2 byte cycles, rsp_rdata=0xFFFFFFFE.
- rst_n low during SPLIT byte 2 of store -> mem_we=0 immediately, no rsp_valid, req_ready=1 after release, bytes 0-1 written, bytes 2-3 unchanged.
